// File: rtl/sram_controller.sv
// sram_controller
// Bridges a 32-bit MEM-stage data port to a 16-bit asynchronous SRAM bus.
// Each word access becomes two halfword transfers (low half, then high half).
// A programmable settle period follows, and then `ready` pulses for one cycle.
// The pipeline stays frozen while `ready` is low.
//
// Ports:
//   clk, rst         - system clock (rising edge), asynchronous active-high reset
//   wr_en, rd_en     - access requests, held by the requester until ready is seen high
//   address, wdata   - byte address (word-aligned) and write data
//   rdata            - read data, valid while ready is high after a read
//   ready            - access complete, or no access pending
//   SRAM_DQ          - bidirectional 16-bit SRAM data bus
//   SRAM_ADDR        - SRAM halfword address {word index, half}
//   SRAM_WE_N        - SRAM write enable, active low
//   SRAM_UB_N/LB_N/CE_N/OE_N - tied active (0)
module sram_controller #(
  parameter int BASE_ADDR   = 1024,
  parameter int WAIT_CYCLES = 2     // settle cycles after both transfers, 0..15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_en,
  input  logic        rd_en,
  input  logic [31:0] address,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ready,
  inout  wire  [15:0] SRAM_DQ,
  output logic [17:0] SRAM_ADDR,
  output logic        SRAM_UB_N,
  output logic        SRAM_LB_N,
  output logic        SRAM_WE_N,
  output logic        SRAM_CE_N,
  output logic        SRAM_OE_N
);

  typedef enum logic [2:0] {IDLE, LOW, HIGH, WAIT, DONE} state_t;

  // Counter value on the final settle cycle; unused when WAIT_CYCLES is 0.
  localparam logic [3:0] WAIT_LAST = 4'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);

  state_t      state;
  state_t      state_next;
  logic        op_wr;
  logic [16:0] idx_q;
  logic [31:0] wdata_q;
  logic [3:0]  wait_cnt;

  logic        req;
  logic [31:0] addr_off;
  logic [16:0] idx_in;
  logic        dq_oe;
  logic [15:0] dq_out;
  logic        unused_addr_bits;

  assign req      = wr_en | rd_en;
  assign addr_off = address - 32'(BASE_ADDR);
  // Word index wraps modulo 2^17; there is deliberately no range check.
  assign idx_in   = addr_off[18:2];
  assign unused_addr_bits = ^{addr_off[31:19], addr_off[1:0]};

  assign SRAM_UB_N = 1'b0;
  assign SRAM_LB_N = 1'b0;
  assign SRAM_CE_N = 1'b0;
  assign SRAM_OE_N = 1'b0;

  // The bus is driven only during the two write transfers. Decoding from the
  // state register lets reset release the bus in the same cycle.
  assign dq_oe   = op_wr && ((state == LOW) || (state == HIGH));
  assign dq_out  = (state == HIGH) ? wdata_q[31:16] : wdata_q[15:0];
  assign SRAM_DQ = dq_oe ? dq_out : 16'bz;

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path through
    // the case statement can leave a value unassigned and infer a latch.
    state_next = state;
    ready      = 1'b0;
    unique case (state)
      IDLE: begin
        ready = ~req;
        if (req) state_next = LOW;
      end
      LOW:  state_next = HIGH;
      HIGH: state_next = (WAIT_CYCLES > 0) ? WAIT : DONE;
      WAIT: if (wait_cnt == WAIT_LAST) state_next = DONE;
      DONE: begin
        ready      = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // NOTE: all state updates use non-blocking assignments, so every register
  // samples the pre-edge values and ordering inside the block does not matter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      op_wr     <= 1'b0;
      idx_q     <= '0;
      wdata_q   <= '0;
      wait_cnt  <= '0;
      rdata     <= '0;
      SRAM_ADDR <= '0;
      SRAM_WE_N <= 1'b1;
    end else begin
      state <= state_next;

      // The request is captured once. Later input changes are ignored until
      // the access returns to IDLE. A simultaneous write and read is a write.
      if (state == IDLE && req) begin
        op_wr   <= wr_en;
        idx_q   <= idx_in;
        wdata_q <= wdata;
      end

      if (state == WAIT) begin
        wait_cnt <= (state_next == DONE) ? 4'd0 : wait_cnt + 4'd1;
      end

      // Address and write strobe are registered from the next state. They are
      // therefore stable for the whole transfer cycle. LOW is entered only from
      // IDLE, so it uses the live index and request.
      SRAM_WE_N <= 1'b1;
      if (state_next == LOW) begin
        SRAM_ADDR <= {idx_in, 1'b0};
        SRAM_WE_N <= ~wr_en;
      end else if (state_next == HIGH) begin
        SRAM_ADDR <= {idx_q, 1'b1};
        SRAM_WE_N <= ~op_wr;
      end

      // Read halves are captured at the closing edge of each transfer.
      if (!op_wr && state == LOW)  rdata[15:0]  <= SRAM_DQ;
      if (!op_wr && state == HIGH) rdata[31:16] <= SRAM_DQ;
    end
  end

endmodule

// File: tb/tb_sram_controller.sv
// tb_sram_controller
// Self-checking bench for sram_controller.
// The main instance runs with WAIT_CYCLES=2 against a small behavioural SRAM.
// Two extra instances (WAIT_CYCLES=0 and 15) are used for the latency extremes.
// Expected read words come from a reference memory. They are queued when a
// read is issued and compared when ready rises.
module tb_sram_controller;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        wr_en, rd_en;
  logic [31:0] address, wdata;
  wire  [31:0] rdata;
  wire         ready;
  wire  [15:0] sram_dq;
  wire  [17:0] sram_addr;
  wire         ub_n, lb_n, we_n, ce_n, oe_n;

  sram_controller #(.BASE_ADDR(1024), .WAIT_CYCLES(2)) u_dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .rd_en(rd_en), .address(address),
    .wdata(wdata), .rdata(rdata), .ready(ready), .SRAM_DQ(sram_dq),
    .SRAM_ADDR(sram_addr), .SRAM_UB_N(ub_n), .SRAM_LB_N(lb_n),
    .SRAM_WE_N(we_n), .SRAM_CE_N(ce_n), .SRAM_OE_N(oe_n)
  );

  // Behavioural SRAM: asynchronous read, write committed on the clock edge.
  logic [15:0] mem [0:63];
  logic        mem_init;
  assign sram_dq = (!ce_n && !oe_n && we_n) ? mem[sram_addr[5:0]] : 16'bz;
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 64; i++) mem[i] <= 16'hC000 | 16'(i);
    end else if (!we_n) begin
      mem[sram_addr[5:0]] <= sram_dq;
    end
  end

  // Latency-extreme instances. The read-only models return addr ^ A5A5.
  logic        aux_rd;
  wire  [31:0] rdata0, rdata15;
  wire         ready0, ready15, we0, we15;
  wire  [15:0] dq0, dq15;
  wire  [17:0] addr0, addr15;
  wire  [3:0]  tie0, tie15;

  sram_controller #(.BASE_ADDR(1024), .WAIT_CYCLES(0)) u_w0 (
    .clk(clk), .rst(rst), .wr_en(1'b0), .rd_en(aux_rd), .address(32'd1024),
    .wdata(32'd0), .rdata(rdata0), .ready(ready0), .SRAM_DQ(dq0),
    .SRAM_ADDR(addr0), .SRAM_UB_N(tie0[0]), .SRAM_LB_N(tie0[1]),
    .SRAM_WE_N(we0), .SRAM_CE_N(tie0[2]), .SRAM_OE_N(tie0[3])
  );
  sram_controller #(.BASE_ADDR(1024), .WAIT_CYCLES(15)) u_w15 (
    .clk(clk), .rst(rst), .wr_en(1'b0), .rd_en(aux_rd), .address(32'd1024),
    .wdata(32'd0), .rdata(rdata15), .ready(ready15), .SRAM_DQ(dq15),
    .SRAM_ADDR(addr15), .SRAM_UB_N(tie15[0]), .SRAM_LB_N(tie15[1]),
    .SRAM_WE_N(we15), .SRAM_CE_N(tie15[2]), .SRAM_OE_N(tie15[3])
  );
  assign dq0  = we0  ? (addr0[15:0]  ^ 16'hA5A5) : 16'bz;
  assign dq15 = we15 ? (addr15[15:0] ^ 16'hA5A5) : 16'bz;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  logic [15:0] ref_mem [0:63];
  logic [31:0] exp_q [$];
  logic [31:0] last_rd;

  task automatic go_idle();
    wr_en = 1'b0;
    rd_en = 1'b0;
  endtask

  // Issue one access right after a rising edge and wait for ready, sampling
  // on falling edges. The access returns #1 after the edge that leaves DONE.
  task automatic access(input logic w, input logic r, input logic [31:0] a,
                        input logic [31:0] d, input string tag);
    int idx, lat, we_low;
    logic [17:0] a_lo, a_hi;
    logic [31:0] exp;
    bit got;
    idx = int'(((a - 32'd1024) >> 2) & 32'h1F);
    wr_en = w; rd_en = r; address = a; wdata = d;
    if (w) begin
      ref_mem[2*idx]   = d[15:0];
      ref_mem[2*idx+1] = d[31:16];
    end else begin
      exp_q.push_back({ref_mem[2*idx+1], ref_mem[2*idx]});
    end
    lat = 0; we_low = 0; got = 0; a_lo = '0; a_hi = '0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (ready) begin
        got = 1;
        break;
      end
      if (c == 1) a_lo = sram_addr;
      if (c == 2) a_hi = sram_addr;
      if (!we_n) begin
        we_low++;
        check({tag, "_dq"}, {16'h0, sram_dq}, {16'h0, (c == 1) ? d[15:0] : d[31:16]});
      end
      lat++;
    end
    check({tag, "_lat"}, 32'(lat), 32'd5);
    check({tag, "_addr_lo"}, {14'h0, a_lo}, 32'(2*idx));
    check({tag, "_addr_hi"}, {14'h0, a_hi}, 32'(2*idx+1));
    check({tag, "_we_cycles"}, 32'(we_low), w ? 32'd2 : 32'd0);
    if (w) begin
      check({tag, "_rdata_kept"}, rdata, last_rd);
    end else begin
      exp = exp_q.pop_front();
      if (got) check({tag, "_rdata"}, rdata, exp);
      last_rd = exp;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    int lat0, lat15;
    bit done0, done15;
    rst = 1'b1; mem_init = 1'b1; aux_rd = 1'b0; last_rd = '0;
    wr_en = 1'b0; rd_en = 1'b0; address = '0; wdata = '0;
    for (int i = 0; i < 64; i++) ref_mem[i] = 16'hC000 | 16'(i);
    repeat (2) @(posedge clk);
    #1;
    mem_init = 1'b0;
    check("rst_ready", {31'h0, ready}, 32'd1);
    check("rst_we_n", {31'h0, we_n}, 32'd1);
    check("rst_rdata", rdata, 32'd0);
    check("rst_addr", {14'h0, sram_addr}, 32'd0);
    check("tied_pins", {28'h0, ub_n, lb_n, ce_n, oe_n}, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    access(1'b1, 1'b0, 32'd1024, 32'hDEADBEEF, "wr0");
    go_idle();
    check("wr0_mem0", {16'h0, mem[0]}, 32'h0000BEEF);
    check("wr0_mem1", {16'h0, mem[1]}, 32'h0000DEAD);
    @(posedge clk); #1;
    access(1'b0, 1'b1, 32'd1024, 32'h0, "rd0");
    go_idle();
    @(posedge clk); #1;

    // Write followed immediately by a read, with no idle cycle between them.
    access(1'b1, 1'b0, 32'd1028, 32'h12345678, "wr1");
    access(1'b0, 1'b1, 32'd1028, 32'h0, "rd1");
    go_idle();
    check("wr1_mem2", {16'h0, mem[2]}, 32'h00005678);
    check("wr1_mem3", {16'h0, mem[3]}, 32'h00001234);
    @(posedge clk); #1;

    // Both requests high: the access must be a write.
    access(1'b1, 1'b1, 32'd1032, 32'hA5A55A5A, "both");
    go_idle();
    check("both_mem4", {16'h0, mem[4]}, 32'h00005A5A);
    check("both_mem5", {16'h0, mem[5]}, 32'h0000A5A5);
    @(posedge clk); #1;

    // Reset during the HIGH transfer: only the low half reaches the SRAM.
    wr_en = 1'b1; address = 32'd1036; wdata = 32'hFFFF0000;
    ref_mem[6] = 16'h0000;
    @(posedge clk); @(posedge clk); #1;
    check("rst_mid_pre_we", {31'h0, we_n}, 32'd0);
    rst = 1'b1;
    #1;
    check("rst_mid_we_n", {31'h0, we_n}, 32'd1);
    check("rst_mid_rdata", rdata, 32'd0);
    last_rd = '0;
    go_idle();
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    check("rst_mid_ready", {31'h0, ready}, 32'd1);
    check("rst_mid_mem6", {16'h0, mem[6]}, 32'h00000000);
    check("rst_mid_mem7", {16'h0, mem[7]}, 32'h0000C007);
    access(1'b0, 1'b1, 32'd1036, 32'h0, "rd_after_rst");
    go_idle();
    @(posedge clk); #1;

    // Latency extremes: WAIT_CYCLES 0 -> 3 cycles, WAIT_CYCLES 15 -> 18 cycles.
    aux_rd = 1'b1;
    lat0 = 99; lat15 = 99; done0 = 0; done15 = 0;
    for (int c = 0; c < 40 && !(done0 && done15); c++) begin
      @(negedge clk);
      if (!done0 && ready0) begin
        done0 = 1; lat0 = c;
        check("w0_rdata", rdata0, 32'hA5A4A5A5);
      end
      if (!done15 && ready15) begin
        done15 = 1; lat15 = c;
        check("w15_rdata", rdata15, 32'hA5A4A5A5);
      end
    end
    check("w0_lat", 32'(lat0), 32'd3);
    check("w15_lat", 32'(lat15), 32'd18);
    @(posedge clk); #1;
    aux_rd = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
